// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP source emulator: output formats,
// pattern modes, frame FSM states and the colour-bar palette.
package dvp_pkg;

    localparam int FMT_RGB565 = 0;
    localparam int FMT_RAW10  = 1;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_e;

    // Eight-bar palette, left to right across the active line.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel colour for the current pixel, selected by the
// mode latched at frame start.
module dvp_pattern_gen
    import dvp_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [15:0] solid,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [2:0]  bar,
    output logic [15:0] pix
);

    // Pixel colour mux
    always_comb begin
        pix = 16'h0000;
        case (mode_e'(mode))
            MODE_BARS:  pix = bar_colour(bar);
            MODE_RAMP:  pix = x + y;
            MODE_SOLID: pix = solid;
            MODE_BLACK: pix = 16'h0000;
            default:    pix = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_source_emu.sv
// Camera-side DVP transmitter: frame timing FSM, line/pixel counters and
// beat packing around the pattern generator. All outputs are registered.
module dvp_source_emu
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10,
    parameter int FORMAT    = 0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic [1:0]  I_mode,
    input  logic [15:0] I_solid,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_pixdata,
    output logic        O_frame_start,
    output logic [15:0] O_frame_cnt
);

    localparam int BPP       = (FORMAT == FMT_RGB565) ? 2 : 1;
    localparam int ACT_BEATS = H_ACTIVE * BPP;
    localparam int LINE      = ACT_BEATS + H_BLANK;
    localparam int BAR_W     = H_ACTIVE / 8;

    state_e      state_r, state_s;
    logic [15:0] h_cnt_r, v_cnt_r;
    logic [15:0] state_lines_s;
    logic        line_end_s, state_done_s, start_s, frame_done_s;
    mode_e       mode_r;
    logic [15:0] solid_r;
    logic [15:0] bar_cnt_r;
    logic [2:0]  bar_idx_r;
    logic [15:0] frame_total_r;
    logic [15:0] x_s, pix_s;
    logic        pix_end_s, href_s;
    logic [9:0]  beat_s;

    logic        vsync_r, href_r, frame_start_r;
    logic [9:0]  pixdata_r;
    logic [15:0] frame_cnt_r;

    assign line_end_s   = (h_cnt_r == 16'(LINE - 1));
    assign state_done_s = line_end_s && (v_cnt_r == state_lines_s - 16'd1);
    assign x_s          = (BPP == 2) ? {1'b0, h_cnt_r[15:1]} : h_cnt_r;
    assign pix_end_s    = (BPP == 1) ? 1'b1 : h_cnt_r[0];
    assign href_s       = (state_r == ST_ACTIVE) && (h_cnt_r < 16'(ACT_BEATS));

    // Frame state register
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a frame once started always runs to the end of VFP
    always_comb begin
        state_s       = state_r;
        state_lines_s = 16'd1;
        start_s       = 1'b0;
        frame_done_s  = 1'b0;
        case (state_r)
            ST_VSYNC:  state_lines_s = 16'(VS_LINES);
            ST_VBP:    state_lines_s = 16'(VBP_LINES);
            ST_ACTIVE: state_lines_s = 16'(V_ACTIVE);
            ST_VFP:    state_lines_s = 16'(VFP_LINES);
            default:   state_lines_s = 16'd1;
        endcase
        case (state_r)
            ST_IDLE: begin
                if (I_enable) begin
                    state_s = ST_VSYNC;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC:  state_s = state_done_s ? ST_VBP : ST_VSYNC;
            ST_VBP:    state_s = state_done_s ? ST_ACTIVE : ST_VBP;
            ST_ACTIVE: state_s = state_done_s ? ST_VFP : ST_ACTIVE;
            ST_VFP: begin
                if (state_done_s) begin
                    frame_done_s = 1'b1;
                    if (I_enable) begin
                        state_s = ST_VSYNC;
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_VFP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Beat and line counters; mode and colour are frozen for the whole frame
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt_r <= 16'd0;
            v_cnt_r <= 16'd0;
            mode_r  <= MODE_BARS;
            solid_r <= 16'h0000;
        end else if (start_s) begin
            h_cnt_r <= 16'd0;
            v_cnt_r <= 16'd0;
            mode_r  <= mode_e'(I_mode);
            solid_r <= I_solid;
        end else if (state_r != ST_IDLE) begin
            if (line_end_s) begin
                h_cnt_r <= 16'd0;
                v_cnt_r <= state_done_s ? 16'd0 : v_cnt_r + 16'd1;
            end else begin
                h_cnt_r <= h_cnt_r + 16'd1;
            end
        end
    end

    // Bar position tracked by a width counter, restarted at every line
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bar_cnt_r <= 16'd0;
            bar_idx_r <= 3'd0;
        end else if (start_s || line_end_s) begin
            bar_cnt_r <= 16'd0;
            bar_idx_r <= 3'd0;
        end else if (href_s && pix_end_s) begin
            if (bar_cnt_r == 16'(BAR_W - 1)) begin
                bar_cnt_r <= 16'd0;
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_cnt_r <= bar_cnt_r + 16'd1;
            end
        end
    end

    // Completed-frame counter
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_total_r <= 16'd0;
        end else if (frame_done_s) begin
            frame_total_r <= frame_total_r + 16'd1;
        end
    end

    dvp_pattern_gen u_pattern (
        .mode  (mode_r),
        .solid (solid_r),
        .x     (x_s),
        .y     (v_cnt_r),
        .bar   (bar_idx_r),
        .pix   (pix_s)
    );

    // Beat packing: RGB565 high byte then low byte, RAW10 from the top bits
    always_comb begin
        beat_s = 10'd0;
        if (FORMAT == FMT_RGB565) begin
            if (h_cnt_r[0]) begin
                beat_s = {pix_s[7:0], 2'b00};
            end else begin
                beat_s = {pix_s[15:8], 2'b00};
            end
        end else if (mode_r == MODE_RAMP) begin
            beat_s = pix_s[9:0];
        end else begin
            beat_s = {pix_s[15:11], pix_s[10:6]};
        end
    end

    // Output registers, one clock behind the counters
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_r       <= 1'b0;
            href_r        <= 1'b0;
            pixdata_r     <= 10'd0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else begin
            vsync_r       <= (state_r == ST_VSYNC);
            href_r        <= href_s;
            pixdata_r     <= href_s ? beat_s : 10'd0;
            frame_start_r <= (state_r == ST_VSYNC) && (h_cnt_r == 16'd0) && (v_cnt_r == 16'd0);
            frame_cnt_r   <= frame_total_r;
        end
    end

    assign O_vsync       = vsync_r;
    assign O_href        = href_r;
    assign O_pixdata     = pixdata_r;
    assign O_frame_start = frame_start_r;
    assign O_frame_cnt   = frame_cnt_r;

endmodule

// File: doc/dvp_source_emu.md
# dvp_source_emu

Camera-side DVP (OV2640-style parallel video port) transmitter that emits VSYNC, HREF and 10-bit PIXDATA frames from an internal pattern generator. It drives the camera capture path (PIXCLK/VSYNC/HREF/PIXDATA into the frame buffer) in simulation and on boards without a sensor fitted. Byte packing is RGB565 two-beat or RAW10 single-beat. Frame timing is fully parameterised.

## Interface

Parameters:
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- H_BLANK, 144: HREF-low clocks per line.
- V_ACTIVE, 480: active lines per frame.
- VS_LINES, 3: lines with VSYNC high.
- VBP_LINES, 17: lines between the VSYNC fall and the first active line.
- VFP_LINES, 10: lines after the last active line.
- FORMAT, 0: 0 = RGB565 (2 beats/pixel), 1 = RAW10 (1 beat/pixel).

Ports:
- I_clk  in  1  beat clock; downstream PIXCLK = ~I_clk.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_enable  in  1  level; permits new frames to start.
- I_mode  in  2  0 = colour bars, 1 = ramp, 2 = solid, 3 = black.
- I_solid  in  16  RGB565 colour used in mode 2.
- O_vsync  out  1  active-high frame sync.
- O_href  out  1  active-high line-valid.
- O_pixdata  out  10  pixel beat.
- O_frame_start  out  1  one-cycle pulse on the rising edge of O_vsync.
- O_frame_cnt  out  16  completed-frame count; wraps.

## Operation

- BPP = 2 when FORMAT = 0, else 1. LINE = H_ACTIVE*BPP + H_BLANK clocks.
- Frame = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES lines.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
- IDLE → VSYNC when I_enable = 1. This transition clears h_cnt and v_cnt and latches I_mode and I_solid for the whole frame.
- Each of VSYNC, VBP, ACTIVE and VFP lasts its programmed line count. h_cnt runs 0..LINE-1, and v_cnt counts lines within the current state.
- VFP end: O_frame_cnt increments by 1 (wraps at 16'hFFFF → 0).
  - If I_enable = 1, go straight to VSYNC (back-to-back frames with no idle gap).
  - Otherwise go to IDLE.
- Dropping I_enable mid-frame never truncates the frame.
- O_vsync = 1 in VSYNC.
- O_href = 1 in ACTIVE while h_cnt < H_ACTIVE*BPP.
- Pixel index x = h_cnt / BPP; line index y = active line number.
- RGB565 beats: even beat = {P[15:8], 2'b00}, odd beat = {P[7:0], 2'b00}.
- RAW10 beat = {P[15:11], P[10:6]}, except ramp mode, which outputs (x + y)[9:0].
- Colour bars: bar = x / (H_ACTIVE/8). Use a bar-width counter; no divider.
  - Bar colours, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Ramp: P = (x + y)[15:0].
- Solid: P = latched I_solid.
- Black: P = 0.
- O_pixdata = 0 whenever O_href = 0.

## Timing

- All outputs are registered and are 0 during reset, including O_frame_cnt.
- Latency: I_enable sampled high at edge N (FSM enters VSYNC) → O_vsync and O_frame_start high after edge N+1.
- O_vsync holds for exactly VS_LINES*LINE clocks.
- First O_href rises (VS_LINES + VBP_LINES)*LINE clocks after the O_vsync rise.
- Each line is H_ACTIVE*BPP clocks of O_href high followed by H_BLANK clocks low.
- Beat data is valid in the same cycle as O_href.
- Asserting I_rst_n low at any time forces all outputs to 0 immediately. After release the FSM starts from IDLE.
- Changes to I_mode or I_solid mid-frame take effect at the next frame.

## Structure

- Package dvp_pkg holds:
  - FORMAT constants (FMT_RGB565, FMT_RAW10),
  - mode encodings,
  - the 8-entry colour-bar table,
  - the FSM state enum.
- One sub-module, dvp_pattern_gen: combinational pixel colour from latched mode, solid colour, x, y and bar index. Timing counters, FSM and beat packing stay in dvp_source_emu.

## Test plan

Unless stated, parameters are H_ACTIVE = 16, H_BLANK = 8, V_ACTIVE = 4, VS_LINES = 2, VBP_LINES = 2, VFP_LINES = 1, FORMAT = 0, giving LINE = 40 and a 360-clock frame.

- Reset: hold I_rst_n low with I_enable = 1 → all outputs 0 and O_frame_cnt = 0. Release → O_vsync rises 2 edges later.
- Frame timing: check the following, then check that a second O_vsync follows immediately with I_enable held.
  - O_vsync is high 80 clocks.
  - The first O_href rises 160 clocks after the O_vsync rise.
  - There are 4 O_href pulses of 32 clocks, each separated by 8 clocks.
  - O_frame_cnt = 1 at clock 360.
- Colour bars, RGB565, mode 0:
  - Beats 0–1 = 10'h3FC, 10'h3FC (white).
  - Beats 4–5 = 10'h3FC, 10'h380 (yellow).
  - Beats 28–31 are the last two pixels and equal 0 (black).
- Ramp, RAW10, FORMAT = 1, mode 1: on active line y = 2, beat x = 5 → O_pixdata = 10'd7, and O_href is 16 clocks wide.
- Enable and mode mid-frame: at clock 100, set I_enable = 0 and I_mode = 2 with I_solid = 16'h1234.
  - The current frame completes still showing bars, then the FSM goes to IDLE with no new O_vsync.
  - Re-enable → the next frame's beats are 10'h048, 10'h0D0.
- Reset mid-active-line: assert I_rst_n low during O_href → O_href, O_pixdata and O_frame_cnt are 0 immediately, and the restart produces a full-length frame.
